// File: rtl/mem_access.sv
// Memory-access stage: one outstanding bus transaction at a time, with
// alignment checks, byte-lane steering, load extension and a bus timeout.
module mem_access #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] inst,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_wdata,
  input  logic        in_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        state_dbg
);

  // Handshakes: upstream presents in_valid and holds its inputs while stall_req
  // is high; a bus access holds bus_req and its fields stable until bus_ack
  // (single cycle) or the timeout, whichever comes first, with ack winning ties.
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [7:0] TMO  = 8'(BUS_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [7:0]  tmo_next;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;
  logic        load_q;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_load;
  logic        is_store;
  logic        mem_op;
  logic        aligned;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic        unused_inst;

  assign op          = inst[6:0];
  assign f3          = inst[14:12];
  assign unused_inst = ^{inst[31:15], inst[11:7]};
  assign is_load     = (op == OP_L) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_store    = (op == OP_S) && (f3 inside {3'b000, 3'b001, 3'b010});
  assign mem_op      = is_load || is_store;
  assign tmo_next    = tmo_cnt + 8'd1;
  assign state_dbg   = (state == WAIT);

  assign stall_req = !rst && (((state == IDLE) && in_valid && mem_op && aligned) ||
                              ((state == WAIT) && !bus_ack));

  always_comb begin
    aligned = 1'b1;
    st_be   = 4'b1111;
    st_data = mem_sdata;
    case (f3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << mem_addr[1:0];
        st_data = {4{mem_sdata[7:0]}};
      end
      2'b01: begin
        aligned = !mem_addr[0];
        st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{mem_sdata[15:0]}};
      end
      2'b10: aligned = (mem_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by access size.
  always_comb begin
    lane_word = bus_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {24'd0, lane_word[7:0]};
      3'b101:  load_data = {16'd0, lane_word[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      f3_q      <= 3'd0;
      lane_q    <= 2'd0;
      rd_q      <= 5'd0;
      load_q    <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'd0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_waddr  <= 5'd0;
      wb_wdata  <= 32'd0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mem_op && !aligned) begin
              wb_valid <= 1'b1;
              misalign <= 1'b1;
              wb_waddr <= in_waddr;
              wb_wdata <= mem_addr;
            end else if (mem_op) begin
              state     <= WAIT;
              tmo_cnt   <= 8'd0;
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {mem_addr[31:2], 2'b00};
              bus_be    <= is_store ? st_be : 4'b1111;
              bus_wdata <= is_store ? st_data : 32'd0;
              f3_q      <= f3;
              lane_q    <= mem_addr[1:0];
              rd_q      <= in_waddr;
              load_q    <= is_load;
            end else begin
              // Unrecognised load/store encodings retire without a write.
              wb_valid <= 1'b1;
              wb_we    <= in_we && (op != OP_L) && (op != OP_S);
              wb_waddr <= in_waddr;
              wb_wdata <= in_wdata;
            end
          end
        end
        WAIT: begin
          if (bus_ack || (tmo_next == TMO)) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
            wb_valid  <= 1'b1;
            wb_waddr  <= rd_q;
            wb_we     <= bus_ack && load_q && (rd_q != 5'd0);
            wb_wdata  <= (bus_ack && load_q) ? load_data : 32'd0;
            bus_err   <= !bus_ack;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus random loads/stores against a
// bus responder with programmable ack delay and a writeback scoreboard.
module tb_mem_access;

  localparam int TMO = 4;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        in_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        stall_req;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        misalign;
  logic        bus_err;
  logic        state_dbg;

  mem_access #(.BUS_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst),
    .in_waddr(in_waddr), .in_wdata(in_wdata), .in_we(in_we),
    .mem_addr(mem_addr), .mem_sdata(mem_sdata), .stall_req(stall_req),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .misalign(misalign),
    .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Entry: [40] data valid to compare, [39] misalign, [38] bus_err, [37] we,
  // [36:32] waddr, [31:0] wdata.
  logic [40:0] exp_q[$];
  logic [40:0] mon_e;
  logic [31:0] last_wdata;
  int          wb_cyc;
  int          acc_cyc;

  // ---------------- bus responder ----------------
  int          ack_delay = -1;
  logic [31:0] rd_word;
  bit          stray_ack = 1'b0;
  int          wait_cnt  = 0;
  logic [31:0] exp_baddr;
  logic [31:0] exp_bwdata;
  logic [3:0]  exp_be;
  logic        exp_bwe;
  int          stall_cnt;
  int          req_cnt;

  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    if (!rst && bus_req) begin
      check("bus_addr", bus_addr, exp_baddr);
      check("bus_be", bus_be, exp_be);
      check("bus_we", bus_we, exp_bwe);
      if (exp_bwe) check("bus_wdata", bus_wdata, exp_bwdata);
      if (wait_cnt == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = rd_word;
      end
      wait_cnt++;
    end else begin
      wait_cnt = 0;
      if (stray_ack) bus_ack = 1'b1;
    end
  end

  always @(negedge clk) begin
    #2;
    if (stall_req) stall_cnt++;
    if (bus_req) req_cnt++;
  end

  // ---------------- writeback monitor ----------------
  always @(negedge clk) begin
    #1;
    if (!rst && wb_valid) begin
      wb_cyc     = cyc;
      last_wdata = wb_wdata;
      if (exp_q.size() == 0) begin
        check("wb_spurious", wb_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_flags", {misalign, bus_err, wb_we}, mon_e[39:37]);
        if (mon_e[40]) begin
          check("wb_waddr", wb_waddr, mon_e[36:32]);
          check("wb_wdata", wb_wdata, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * addr[1:0]);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] st_be(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'b000) return 4'b0001 << addr[1:0];
    if (f3 == 3'b001) return addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b000) return {4{d[7:0]}};
    if (f3 == 3'b001) return {2{d[15:0]}};
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] wdata, input logic we, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [40:0] e, input bit push);
    logic [31:0] r;
    @(negedge clk);
    r         = $urandom;
    inst      = {r[31:15], f3, rd, op};
    in_waddr  = rd;
    in_wdata  = wdata;
    in_we     = we;
    mem_addr  = addr;
    mem_sdata = sdata;
    stall_cnt = 0;
    req_cnt   = 0;
    acc_cyc   = cyc;
    if (push) exp_q.push_back(e);
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #3;
      done = (exp_q.size() == 0) && !bus_req;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic do_alu(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] wdata, input logic we, input logic exp_we);
    issue(op, f3, rd, wdata, we, $urandom, $urandom, {1'b1, 2'b00, exp_we, rd, wdata}, 1'b1);
    wait_done("alu");
    check("alu_lat", wb_cyc - acc_cyc, 1);
    check("alu_req", req_cnt, 0);
  endtask

  task automatic do_mem(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input int dly, input logic [31:0] rword);
    logic [40:0] e;
    bit          mis;
    int          exp_req;
    int          exp_lat;
    mis = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    if (mis) begin
      e = {1'b0, 3'b100, 37'd0};
      exp_req = 0;
      exp_lat = 1;
    end else if (dly < 0 || dly >= TMO) begin
      e = {1'b0, 3'b010, 37'd0};
      exp_req = TMO;
      exp_lat = TMO + 1;
    end else begin
      exp_req = dly + 1;
      exp_lat = dly + 2;
      e = st ? {1'b0, 3'b000, 37'd0}
             : {1'b1, 2'b00, (rd != 5'd0), rd, load_fmt(f3, addr, rword)};
    end
    exp_baddr  = {addr[31:2], 2'b00};
    exp_be     = st ? st_be(f3, addr) : 4'b1111;
    exp_bwe    = st;
    exp_bwdata = st_data(f3, sdata);
    ack_delay  = dly;
    rd_word    = rword;
    issue(st ? OP_S : OP_L, f3, rd, $urandom, 1'b1, addr, sdata, e, 1'b1);
    wait_done("mem");
    check("mem_lat", wb_cyc - acc_cyc, exp_lat);
    check("mem_req", req_cnt, exp_req);
  endtask

  // ---------------- test sequence ----------------
  bit          r_st;
  logic [2:0]  r_f3;
  int          r_k;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    inst      = {17'd0, 3'b010, 5'd1, OP_L};
    in_waddr  = 5'd1;
    in_wdata  = 32'hFFFF_FFFF;
    in_we     = 1'b1;
    mem_addr  = 32'h0000_0100;
    mem_sdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #3;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_bus_be", bus_be, 4'd0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_waddr", wb_waddr, 5'd0);
    check("rst_wb_wdata", wb_wdata, 32'd0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_stall", stall_req, 1'b0);
    check("rst_state", state_dbg, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // ALU result passthrough
    do_alu(OP_R, 3'b000, 5'd3, 32'h0000_0005, 1'b1, 1'b1);
    check("add_data", last_wdata, 32'h0000_0005);

    // LB from the top byte lane, ack after two waits
    do_mem(1'b0, 3'b000, 5'd5, 32'h0000_1003, 32'd0, 2, 32'h80FF_FFFF);
    check("lb_stall", stall_cnt, 3);
    check("lb_data", last_wdata, 32'hFFFF_FF80);

    // SH to the upper half
    do_mem(1'b1, 3'b001, 5'd0, 32'h0000_2002, 32'h0000_BEEF, 1, 32'd0);

    // Misaligned LW
    do_mem(1'b0, 3'b010, 5'd4, 32'h0000_0006, 32'd0, 0, 32'h1234_5678);
    check("mis_stall", stall_cnt, 0);

    // Timeout, then ack arriving in the timeout cycle
    do_mem(1'b0, 3'b010, 5'd6, 32'h0000_4000, 32'd0, -1, 32'd0);
    check("tmo_state", state_dbg, 1'b0);
    do_mem(1'b0, 3'b010, 5'd6, 32'h0000_4004, 32'd0, TMO - 1, 32'hCAFE_F00D);
    check("ackwin_data", last_wdata, 32'hCAFE_F00D);

    // Load to x0, zero-extended halfword
    do_mem(1'b0, 3'b100, 5'd0, 32'h0000_5001, 32'd0, 0, 32'h00A5_0000);
    do_mem(1'b0, 3'b101, 5'd9, 32'h0000_5002, 32'd0, 1, 32'h8765_4321);
    check("lhu_data", last_wdata, 32'h0000_8765);

    // Unknown funct3 on load and store opcodes
    do_alu(OP_L, 3'b011, 5'd7, 32'h0000_1234, 1'b1, 1'b0);
    do_alu(OP_S, 3'b100, 5'd8, 32'h0000_5678, 1'b1, 1'b0);

    // Ack while idle must do nothing
    stray_ack = 1'b1;
    req_cnt   = 0;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    #3;
    check("stray_req", req_cnt, 0);

    // Reset while waiting on the bus
    exp_baddr = 32'h0000_3000;
    exp_be    = 4'b1111;
    exp_bwe   = 1'b0;
    ack_delay = -1;
    issue(OP_L, 3'b010, 5'd9, 32'd0, 1'b1, 32'h0000_3000, 32'd0, 41'd0, 1'b0);
    check("abort_inwait", state_dbg, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("abort_req", bus_req, 1'b0);
    check("abort_stall", stall_req, 1'b0);
    check("abort_state", state_dbg, 1'b0);
    repeat (3) @(negedge clk);
    do_mem(1'b0, 3'b010, 5'd10, 32'h0000_3008, 32'd0, 0, 32'h1357_9BDF);

    // Random loads and stores
    for (int i = 0; i < 24; i++) begin
      r_st = 1'($urandom_range(0, 1));
      if (r_st) begin
        r_f3 = 3'($urandom_range(0, 2));
      end else begin
        r_k  = $urandom_range(0, 4);
        r_f3 = (r_k > 2) ? 3'(r_k + 1) : 3'(r_k);
      end
      do_mem(r_st, r_f3, 5'($urandom_range(0, 31)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter BUS_TIMEOUT, default 255: maximum number of WAIT-state cycles without bus_ack before a bus error (range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 in_valid  input  1  execute-stage result valid this cycle.
REQ-005 inst  input  32  instruction; op = inst[6:0], funct3 = inst[14:12].
REQ-006 in_waddr  input  5  destination register.
REQ-007 in_wdata  input  32  execute result, passed through for non-memory ops.
REQ-008 in_we  input  1  destination write enable from execute.
REQ-009 mem_addr  input  32  effective load/store address.
REQ-010 mem_sdata  input  32  store source data (rs2).
REQ-011 stall_req  output  1  hold upstream; inputs stay stable while it is high.
REQ-012 bus_req, bus_we  output  1 each  bus request and write strobe.
REQ-013 bus_addr  output  32  word-aligned address; bits [1:0] are always 0.
REQ-014 bus_wdata  output  32  lane-positioned store data.
REQ-015 bus_be  output  4  byte enables.
REQ-016 bus_rdata  input  32  read data, valid only when bus_ack is high.
REQ-017 bus_ack  input  1  single-cycle completion.
REQ-018 wb_valid, wb_we  output  1 each  registered result valid and write enable to writeback.
REQ-019 wb_waddr  output  5  registered destination; wb_wdata  output  32  registered data.
REQ-020 misalign, bus_err  output  1 each  one-cycle exception pulses, aligned with wb_valid.

Function
REQ-021 States SHALL be IDLE and WAIT.
REQ-022 IDLE, in_valid, non-load/store op: the next cycle SHALL give wb_valid=1 and wb_* = in_*; stall_req=0; latency 1.
REQ-023 IDLE, in_valid, load (OP_L) or store (OP_S), aligned: capture address, be, wdata and dest; go to WAIT; stall_req=1 this cycle.
REQ-024 Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0; bytes are always aligned.
REQ-025 Misaligned op: no bus access, stay IDLE; next cycle SHALL give wb_valid=1, wb_we=0, misalign=1; stall_req=0.
REQ-026 WAIT: bus_req=1; bus_addr, bus_be, bus_wdata and bus_we SHALL stay constant until bus_ack.
REQ-027 WAIT: stall_req = !bus_ack.
REQ-028 WAIT with bus_ack: go to IDLE; the next cycle SHALL give wb_valid=1 with the formatted result.
REQ-029 Store enables: SB be = 4'b0001 << addr[1:0] with the byte replicated on all lanes; SH be = 0011 (addr[1]=0) or 1100 (addr[1]=1) with the half replicated; SW be = 1111.
REQ-030 Stores SHALL give wb_we=0.
REQ-031 Load data: LB/LBU select byte lane addr[1:0]; LH/LHU select half lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-032 Load with rd=0 SHALL give wb_we=0.
REQ-033 Unknown load/store funct3 SHALL be treated as a non-memory op with wb_we=0.
REQ-034 The timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-035 When the counter reaches BUS_TIMEOUT: drop bus_req, return to IDLE, and the next cycle SHALL give wb_valid=1, wb_we=0, bus_err=1.
REQ-036 bus_ack in the same cycle as the timeout SHALL count as ack (ack wins).
REQ-037 bus_ack while in IDLE SHALL be ignored.
REQ-038 wb_valid SHALL be 0 in any cycle not produced by REQ-022, 025, 028 or 035.

Reset
REQ-039 On rst: state=IDLE, timeout counter=0; all outputs 0 (bus_req, bus_we, bus_addr, bus_wdata, bus_be, wb_valid, wb_we, wb_waddr, wb_wdata, misalign, bus_err, stall_req).
REQ-040 rst in WAIT SHALL abort the access: bus_req=0 in the following cycle; no wb_valid is produced for the aborted op.

Verification
REQ-041 ADD result 0x00000005 to rd=3 -> one cycle later wb_valid=1, wb_we=1, wb_waddr=3, wb_wdata=0x00000005, no bus activity.
REQ-042 LB at addr 0x1003, ack after 2 cycles with rdata=0x80FFFFFF -> bus_addr=0x1000, bus_be=1111, bus_we=0, stall_req high for 3 cycles, then wb_wdata=0xFFFFFF80.
REQ-043 SH of sdata=0x0000BEEF at addr 0x2002 -> bus_we=1, bus_be=1100, bus_wdata=0xBEEFBEEF, wb_we=0.
REQ-044 LW at addr 0x0006 -> misalign=1, wb_we=0, bus_req never asserted.
REQ-045 BUS_TIMEOUT=4, LW with no ack -> bus_req high for 4 cycles, then bus_err=1, wb_we=0, state=IDLE.
REQ-046 rst asserted during WAIT -> next cycle bus_req=0 and stall_req=0; no wb_valid for the aborted op; the next op completes normally.
